// File: rtl/inference_ctrl.sv
// inference_ctrl: sequences one CNN inference. It pulses the network start,
// meters INPUT_LENGTH host samples into the network, waits (with optional
// timeout) for the score vector, finds the argmax serially and presents the
// result on a valid/yumi interface.
module inference_ctrl #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned INPUT_LENGTH   = 256,
  parameter int unsigned OUTPUT_SIZE    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cmd_start_i,
  input  logic                              abort_i,
  output logic                              busy_o,
  output logic                              error_o,
  input  logic [WORD_SIZE-1:0]              data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic                              net_start_o,
  output logic [WORD_SIZE-1:0]              net_data_o,
  output logic                              net_valid_o,
  input  logic                              net_ready_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]  net_data_i,
  input  logic                              net_valid_i,
  output logic                              net_yumi_o,
  output logic [OUTPUT_SIZE*WORD_SIZE-1:0]  data_o,
  output logic [$clog2(OUTPUT_SIZE)-1:0]    class_o,
  output logic                              valid_o,
  input  logic                              yumi_i
);

  localparam int unsigned IW = $clog2(OUTPUT_SIZE);
  localparam int unsigned CW = $clog2(INPUT_LENGTH + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned VW = OUTPUT_SIZE * WORD_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_ARGMAX,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic [VW-1:0]        data_q, data_d;
  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic [WORD_SIZE-1:0] best_val_q, best_val_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WORD_SIZE-1:0] elem;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      data_q     <= data_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      idx_q      <= idx_d;
    end
  end

  // Select the captured score currently under comparison.
  always_comb begin
    elem = '0;
    for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
      if (idx_q == IW'(k)) begin
        elem = data_q[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Next-state and register update logic; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    data_d     = data_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    idx_d      = idx_q;

    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            state_d = S_START;
            err_d   = 1'b0;
          end
        end

        S_START: begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_STREAM;
        end

        S_STREAM: begin
          if (valid_i && net_ready_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(INPUT_LENGTH - 1)) begin
              state_d = S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // Arriving scores take precedence over an expiring timeout.
          if (net_valid_i) begin
            data_d     = net_data_i;
            best_idx_d = '0;
            best_val_d = net_data_i[WORD_SIZE-1:0];
            idx_d      = IW'(1);
            tmo_d      = '0;
            state_d    = S_ARGMAX;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
              err_d   = 1'b1;
              tmo_d   = '0;
              state_d = S_IDLE;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end

        S_ARGMAX: begin
          // Strictly greater only, so ties keep the lower index.
          if ($signed(elem) > $signed(best_val_q)) begin
            best_val_d = elem;
            best_idx_d = idx_q;
          end
          if (idx_q == IW'(OUTPUT_SIZE - 1)) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end

        S_DONE: begin
          if (yumi_i) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state plus pass-through handshakes.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    error_o     = err_q;
    net_start_o = (state_q == S_START);
    ready_o     = (state_q == S_STREAM) && net_ready_i;
    net_valid_o = (state_q == S_STREAM) && valid_i;
    net_data_o  = data_i;
    net_yumi_o  = (state_q == S_WAIT) && net_valid_i;
    valid_o     = (state_q == S_DONE);
    data_o      = data_q;
    class_o     = best_idx_q;
  end

endmodule

// File: tb/tb_inference_ctrl.sv
// Self-checking bench for inference_ctrl: directed scenarios plus randomized
// inferences, checked against a plain argmax/handshake-count reference.
module tb_inference_ctrl;

  localparam int WS = 16;
  localparam int IL = 8;
  localparam int OS = 10;
  localparam int TO = 20;
  localparam int VW = OS * WS;
  localparam int CLW = $clog2(OS);

  logic           clk = 1'b0;
  logic           reset_i;
  logic           cmd_start_i;
  logic           abort_i;
  logic           busy_o;
  logic           error_o;
  logic [WS-1:0]  data_i;
  logic           valid_i;
  logic           ready_o;
  logic           net_start_o;
  logic [WS-1:0]  net_data_o;
  logic           net_valid_o;
  logic           net_ready_i;
  logic [VW-1:0]  net_data_i;
  logic           net_valid_i;
  logic           net_yumi_o;
  logic [VW-1:0]  data_o;
  logic [CLW-1:0] class_o;
  logic           valid_o;
  logic           yumi_i;

  int total = 0;
  int bad = 0;
  int sc[OS];

  inference_ctrl #(
    .WORD_SIZE     (WS),
    .INPUT_LENGTH  (IL),
    .OUTPUT_SIZE   (OS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cmd_start_i(cmd_start_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .error_o    (error_o),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .net_start_o(net_start_o),
    .net_data_o (net_data_o),
    .net_valid_o(net_valid_o),
    .net_ready_i(net_ready_i),
    .net_data_i (net_data_i),
    .net_valid_i(net_valid_i),
    .net_yumi_o (net_yumi_o),
    .data_o     (data_o),
    .class_o    (class_o),
    .valid_o    (valid_o),
    .yumi_i     (yumi_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: index of the first maximum over the signed score list.
  function automatic int ref_argmax();
    int best = 0;
    for (int k = 1; k < OS; k++) begin
      if (sc[k] > sc[best]) best = k;
    end
    return best;
  endfunction

  function automatic logic [VW-1:0] pack_sc();
    logic [VW-1:0] v = '0;
    for (int k = 0; k < OS; k++) v[k*WS +: WS] = WS'(sc[k]);
    return v;
  endfunction

  task automatic inputs_idle();
    cmd_start_i = 1'b0;
    abort_i     = 1'b0;
    data_i      = '0;
    valid_i     = 1'b0;
    net_ready_i = 1'b0;
    net_data_i  = '0;
    net_valid_i = 1'b0;
    yumi_i      = 1'b0;
  endtask

  // Issue start in IDLE; the pulse must appear exactly one cycle later.
  task automatic do_start(input logic exp_err_idle);
    cmd_start_i = 1'b1;
    net_ready_i = 1'b1;
    valid_i     = 1'b1;
    data_i      = 16'h0055;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_net_start", net_start_o, 0);
    chk("idle_ready", ready_o, 0);
    chk("idle_error", error_o, exp_err_idle);
    tick();
    cmd_start_i = 1'b0;
    #1;
    chk("start_pulse", net_start_o, 1);
    chk("start_busy", busy_o, 1);
    chk("start_ready", ready_o, 0);
    chk("start_net_valid", net_valid_o, 0);
    chk("start_error_cleared", error_o, 0);
    tick();
  endtask

  // Stream until the bench has counted stop_at handshakes.
  task automatic run_stream(input int mode, input int stop_at);
    int n = 0;
    int cyc = 0;
    while (n < stop_at && cyc < 200) begin
      case (mode)
        0: begin net_ready_i = 1'b1; valid_i = 1'b1; end
        1: begin net_ready_i = (cyc % 2 == 0); valid_i = 1'b1; end
        default: begin
          net_ready_i = 1'($urandom_range(0, 1));
          valid_i     = 1'($urandom_range(0, 1));
        end
      endcase
      data_i      = WS'($urandom);
      cmd_start_i = 1'($urandom_range(0, 1));
      #1;
      chk("stream_ready", ready_o, net_ready_i);
      chk("stream_net_valid", net_valid_o, valid_i);
      chk("stream_net_data", net_data_o, data_i);
      chk("stream_net_start", net_start_o, 0);
      if (valid_i && net_ready_i) n++;
      tick();
      cyc++;
    end
    chk("stream_bound", n, stop_at);
    cmd_start_i = 1'b0;
    valid_i     = 1'b0;
  endtask

  // First WAIT cycle: excess host samples must stall.
  task automatic post_stream_check();
    net_ready_i = 1'b1;
    valid_i     = 1'b1;
    data_i      = 16'hBEEF;
    net_valid_i = 1'b0;
    #1;
    chk("wait_ready", ready_o, 0);
    chk("wait_net_valid", net_valid_o, 0);
    chk("wait_busy", busy_o, 1);
    chk("wait_yumi_idle", net_yumi_o, 0);
    tick();
  endtask

  // Present scores after `delay` more WAIT cycles, then check argmax result.
  task automatic deliver(input int delay, input logic yumi_early, input int hold);
    logic [VW-1:0] vec;
    int exp_cls;
    vec = pack_sc();
    exp_cls = ref_argmax();
    for (int i = 0; i < delay; i++) begin
      net_valid_i = 1'b0;
      #1;
      chk("wait_no_yumi", net_yumi_o, 0);
      chk("wait_busy_hold", busy_o, 1);
      tick();
    end
    net_valid_i = 1'b1;
    net_data_i  = vec;
    #1;
    chk("net_yumi", net_yumi_o, 1);
    chk("wait_ready_capture", ready_o, 0);
    tick();
    net_valid_i = 1'b0;
    valid_i     = 1'b0;
    for (int i = 1; i < OS; i++) begin
      net_data_i = {5{32'($urandom)}};
      yumi_i     = yumi_early;
      #1;
      chk("argmax_valid_low", valid_o, 0);
      chk("argmax_yumi_low", net_yumi_o, 0);
      chk("argmax_data", data_o, vec);
      tick();
    end
    yumi_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_start_i = 1'($urandom_range(0, 1));
      #1;
      chk("done_valid", valid_o, 1);
      chk("done_class", class_o, exp_cls);
      chk("done_data", data_o, vec);
      tick();
    end
    cmd_start_i = 1'b0;
    yumi_i      = 1'b1;
    #1;
    chk("done_valid_at_yumi", valid_o, 1);
    chk("done_class_at_yumi", class_o, exp_cls);
    chk("done_data_at_yumi", data_o, vec);
    tick();
    yumi_i = 1'b0;
    #1;
    chk("post_busy", busy_o, 0);
    chk("post_valid", valid_o, 0);
    chk("post_class_kept", class_o, exp_cls);
    chk("post_data_kept", data_o, vec);
    chk("post_error", error_o, 0);
  endtask

  task automatic infer(input int mode, input int delay, input logic yumi_early, input int hold);
    do_start(1'b0);
    run_stream(mode, IL);
    post_stream_check();
    deliver(delay, yumi_early, hold);
  endtask

  initial begin
    inputs_idle();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_net_start", net_start_o, 0);
    chk("rst_net_valid", net_valid_o, 0);
    chk("rst_net_yumi", net_yumi_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, '0);
    chk("rst_class", class_o, 0);

    // yumi in IDLE is ignored
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    chk("idle_yumi_ignored", busy_o, 0);

    // Tie at top score keeps lower index.
    sc = '{3, -5, 7, 7, 0, -1, 2, 6, 1, -8};
    infer(0, 2, 1'b0, 0);

    // All negative, ready toggling, yumi held off 5 cycles.
    sc = '{-9, -2, -4, -7, -3, -5, -6, -8, -10, -11};
    infer(1, 0, 1'b1, 5);

    // Maximum in the last slot; then all equal.
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
    infer(2, 3, 1'b0, 1);
    sc = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    infer(2, 1, 1'b1, 2);

    // Randomized inferences, small and full-range scores.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < OS; k++) begin
        if (r % 2 == 0) sc[k] = int'($urandom_range(0, 7)) - 4;
        else            sc[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      infer(2, int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    // Timeout: network never answers.
    do_start(1'b0);
    run_stream(0, IL);
    post_stream_check();
    for (int i = 1; i < TO; i++) begin
      net_valid_i = 1'b0;
      #1;
      chk("tmo_busy", busy_o, 1);
      chk("tmo_error_low", error_o, 0);
      tick();
    end
    #1;
    chk("tmo_idle", busy_o, 0);
    chk("tmo_error", error_o, 1);

    // start+abort together in IDLE: stay, error unchanged.
    cmd_start_i = 1'b1;
    abort_i     = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    abort_i     = 1'b0;
    #1;
    chk("start_abort_idle", busy_o, 0);
    chk("start_abort_error", error_o, 1);

    sc = '{1, 2, 3, -4, 9, 0, 0, 8, 9, 1};
    do_start(1'b1);
    run_stream(0, IL);
    post_stream_check();
    deliver(1, 1'b0, 0);

    // Abort mid-stream after 4 samples.
    do_start(1'b0);
    run_stream(0, 4);
    abort_i = 1'b1;
    tick();
    abort_i     = 1'b0;
    net_ready_i = 1'b1;
    valid_i     = 1'b1;
    #1;
    chk("abort_stream_busy", busy_o, 0);
    chk("abort_stream_ready", ready_o, 0);
    chk("abort_stream_net_valid", net_valid_o, 0);
    chk("abort_stream_valid", valid_o, 0);
    chk("abort_stream_error", error_o, 0);
    tick();
    #1;
    chk("abort_stream_ready2", ready_o, 0);
    valid_i = 1'b0;

    // Counter must restart from zero after abort.
    sc = '{-1, -1, 0, 2, 1, 2, -3, 0, 0, 1};
    infer(0, 0, 1'b0, 0);

    // Abort in ARGMAX.
    sc = '{5, 1, 2, 3, 4, 20, 6, 7, 8, 9};
    do_start(1'b0);
    run_stream(0, IL);
    post_stream_check();
    net_valid_i = 1'b1;
    net_data_i  = pack_sc();
    #1;
    chk("abort_arg_yumi", net_yumi_o, 1);
    tick();
    net_valid_i = 1'b0;
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("abort_arg_valid", valid_o, 0);
      chk("abort_arg_busy", busy_o, 0);
      chk("abort_arg_error", error_o, 0);
      tick();
    end

    // Reset while waiting.
    sc = '{0, 3, 1, 1, 1, 1, 1, 1, 1, 1};
    infer(0, 0, 1'b0, 0);
    do_start(1'b0);
    run_stream(0, IL);
    post_stream_check();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    inputs_idle();
    #1;
    chk("rst2_busy", busy_o, 0);
    chk("rst2_error", error_o, 0);
    chk("rst2_ready", ready_o, 0);
    chk("rst2_net_start", net_start_o, 0);
    chk("rst2_net_valid", net_valid_o, 0);
    chk("rst2_net_yumi", net_yumi_o, 0);
    chk("rst2_valid", valid_o, 0);
    chk("rst2_data", data_o, '0);
    chk("rst2_class", class_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inference_ctrl.md
Name: inference_ctrl

Overview:
- Top-level sequencer for one inference of the CNN pipeline.
- Takes a software/host start command and pulses the network start.
- Meters exactly INPUT_LENGTH samples from the host stream into the network's input handshake.
- Waits, with a timeout, for the final FC layer's output vector and captures it.
- Computes the argmax class serially and presents vector plus class on a valid/yumi result interface.

Parameters:
WORD_SIZE, 16, bit width of samples and output scores (signed fixed point)
INPUT_LENGTH, 256, samples per inference frame
OUTPUT_SIZE, 10, number of class scores from the network; must be >= 2
TIMEOUT_CYCLES, 65535, max WAIT cycles before error; 0 disables timeout

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; one clock, synchronous, active-high
cmd_start_i  in  1  begin inference (honoured only in IDLE)
abort_i  in  1  cancel current inference
busy_o  out  1  high in every state except IDLE
error_o  out  1  sticky timeout flag
data_i  in  WORD_SIZE  host sample
valid_i  in  1  host sample valid
ready_o  out  1  host sample accepted when valid_i&ready_o
net_start_o  out  1  one-cycle start pulse to network
net_data_o  out  WORD_SIZE  sample to network (combinational copy of data_i)
net_valid_o  out  1  sample valid to network
net_ready_i  in  1  network ready for sample
net_data_i  in  OUTPUT_SIZE*WORD_SIZE  packed network scores, element k at [k]
net_valid_i  in  1  network scores valid
net_yumi_o  out  1  consume network scores
data_o  out  OUTPUT_SIZE*WORD_SIZE  captured scores
class_o  out  $clog2(OUTPUT_SIZE)  argmax index
valid_o  out  1  result valid
yumi_i  in  1  result consumed

Behaviour:
- Reset:
  - state = IDLE.
  - All 1-bit outputs = 0; data_o = 0; class_o = 0; counters = 0; error_o = 0.
- FSM states: IDLE, START, STREAM, WAIT, ARGMAX, DONE.
- IDLE:
  - On cmd_start_i: go to START and clear error_o.
- START:
  - net_start_o = 1 for exactly this cycle.
  - Sample counter cleared.
  - Next state: STREAM.
- STREAM:
  - ready_o = net_ready_i; net_valid_o = valid_i; net_data_o = data_i, all combinational.
  - Each transfer (valid_i & net_ready_i) increments the counter.
  - The transfer that makes count == INPUT_LENGTH moves to WAIT next cycle.
- Outside STREAM: ready_o = 0 and net_valid_o = 0. Excess host samples stall and are never forwarded.
- WAIT:
  - Timeout counter increments each cycle net_valid_i = 0.
  - On net_valid_i = 1:
    - net_yumi_o = 1 that cycle (combinational).
    - net_data_i is registered into data_o.
    - best_idx = 0; best_val = element 0.
    - Next state: ARGMAX with idx = 1.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no net_valid_i: error_o <= 1 and go to IDLE.
  - net_valid_i wins over timeout in the same cycle.
- ARGMAX:
  - One signed compare per cycle, element idx vs best_val.
  - Strictly greater replaces best; ties keep the lower index.
  - idx increments; after idx = OUTPUT_SIZE-1 is compared, go to DONE.
- DONE:
  - valid_o = 1; class_o = best_idx; data_o held stable.
  - On yumi_i: go to IDLE next cycle, valid_o drops.
  - yumi_i while valid_o = 0 is ignored.
- Latency:
  - Scores captured in cycle t give valid_o = 1 in cycle t+OUTPUT_SIZE.
  - net_start_o occurs one cycle after cmd_start_i is sampled in IDLE.
- abort_i:
  - Highest priority after reset; any state goes to IDLE next cycle.
  - valid_o = 0, error_o unchanged, counters cleared.
  - Partially streamed data is not flushed from the network; the host must reset the network.
- cmd_start_i outside IDLE: ignored, no queueing.
- cmd_start_i and abort_i both high in IDLE: stay IDLE.
- data_o / class_o retain their last values in IDLE until the next capture.

Test Plan:
- INPUT_LENGTH=8, net_ready_i=1, 8 host samples 1..8: net_start_o pulses one cycle after cmd_start_i; exactly 8 transfers forwarded; 9th sample sees ready_o=0.
- net_ready_i toggling 1,0,1,0 during stream: counter advances only on valid&ready; WAIT entered after 8th handshake.
- Scores {3,-5,7,7,0,-1,2,6,1,-8} presented: net_yumi_o high for one cycle; valid_o rises 10 cycles later with class_o=2 (tie keeps lowest index) and data_o equal to captured vector.
- All scores negative {-9,-2,-4,...}: class_o=1; yumi_i held low 5 cycles, so outputs stay stable; yumi_i=1 returns busy_o=0 next cycle.
- TIMEOUT_CYCLES=20, network never responds: error_o=1 and busy_o=0 after 20 WAIT cycles; next cmd_start_i clears error_o.
- abort_i asserted mid-STREAM at sample 4, and separately in ARGMAX: IDLE next cycle, ready_o=0, valid_o never asserted, error_o=0; synchronous reset mid-WAIT gives all outputs 0.
